// File: rtl/mem_pkg.sv
// Shared memory-subsystem definitions: arbiter state codes, access widths,
// and the console MMIO address used by the snooping logic outside the arbiter.
package mem_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_IBUSY = 2'd1;
  localparam logic [1:0] ST_DBUSY = 2'd2;

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;

  localparam logic [31:0] CONSOLE_ADDR = 32'h000F_0000;

  // The reserved width code 3 is folded onto a full-word access.
  function automatic logic [1:0] norm_width(input logic [1:0] w);
    return (w == 2'd3) ? W_WORD : w;
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the two pipeline requesters, the arbiter
// and the unified RAM. The slave modport is the arbiter's view.
interface mem_arbiter_if #(parameter int AW = 32);
  logic          i_valid_i, i_ready_o, i_rvalid_ro;
  logic [AW-1:0] i_addr_i;
  logic [31:0]   i_rdata_ro;

  logic          d_valid_i, d_ready_o, d_write_i, d_rvalid_ro;
  logic [AW-1:0] d_addr_i;
  logic [31:0]   d_wdata_i, d_rdata_ro;
  logic [1:0]    d_width_i;

  logic          flush_i;

  logic          mem_cke_o, mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o, mem_rdata_i;
  logic [1:0]    mem_width_o;

  modport slave (
    input  i_valid_i, i_addr_i, d_valid_i, d_addr_i, d_wdata_i, d_write_i,
           d_width_i, flush_i, mem_rdata_i,
    output i_ready_o, i_rvalid_ro, i_rdata_ro, d_ready_o, d_rvalid_ro,
           d_rdata_ro, mem_cke_o, mem_addr_o, mem_wdata_o, mem_write_o,
           mem_width_o
  );

  modport master (
    output i_valid_i, i_addr_i, d_valid_i, d_addr_i, d_wdata_i, d_write_i,
           d_width_i, flush_i, mem_rdata_i,
    input  i_ready_o, i_rvalid_ro, i_rdata_ro, d_ready_o, d_rvalid_ro,
           d_rdata_ro, mem_cke_o, mem_addr_o, mem_wdata_o, mem_write_o,
           mem_width_o
  );
endinterface

// File: rtl/arb_grant2.sv
// Combinational two-way grant. Data wins ties by default; with
// ARB_ROUND_ROBIN_EN the side that did not win last time wins the tie.
module arb_grant2 (
  input  logic i_req,
  input  logic d_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_d,
`endif
  output logic gnt_i,
  output logic gnt_d
);
`ifdef ARB_ROUND_ROBIN_EN
  assign gnt_d = d_req & (~i_req | ~last_d);
`else
  assign gnt_d = d_req;
`endif
  assign gnt_i = i_req & ~gnt_d;
endmodule

// File: rtl/mem_arbiter.sv
// Single-port unified memory arbiter for instruction fetch and data access.
// Optional ARB_ROUND_ROBIN_EN replaces fixed data priority with alternation.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int AW      = 32
) (
  input  logic clk,
  input  logic rst,
  mem_arbiter_if.slave bus
);
  logic [1:0]    state;
  logic [1:0]    cnt;
  logic          flush_pend;
  logic [AW-1:0] addr_q;
  logic [1:0]    width_q;
  logic          gnt_i, gnt_d, idle, i_acc, d_acc;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  always_ff @(posedge clk) begin
    if (rst)                last_d <= 1'b1;
    else if (i_acc | d_acc) last_d <= d_acc;
  end
`endif

  arb_grant2 u_grant (
    .i_req  (bus.i_valid_i),
    .d_req  (bus.d_valid_i),
`ifdef ARB_ROUND_ROBIN_EN
    .last_d (last_d),
`endif
    .gnt_i  (gnt_i),
    .gnt_d  (gnt_d)
  );

  assign idle          = (state == ST_IDLE);
  assign bus.i_ready_o = idle & gnt_i;
  assign bus.d_ready_o = idle & gnt_d;
  assign i_acc         = bus.i_valid_i & bus.i_ready_o;
  assign d_acc         = bus.d_valid_i & bus.d_ready_o;

  always_comb begin
    bus.mem_cke_o   = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.mem_write_o = 1'b0;
    bus.mem_width_o = '0;
    if (idle) begin
      if (d_acc) begin
        bus.mem_cke_o   = 1'b1;
        bus.mem_addr_o  = bus.d_addr_i;
        bus.mem_wdata_o = bus.d_wdata_i;
        bus.mem_write_o = bus.d_write_i;
        bus.mem_width_o = norm_width(bus.d_width_i);
      end else if (i_acc) begin
        bus.mem_cke_o   = 1'b1;
        bus.mem_addr_o  = bus.i_addr_i;
        bus.mem_width_o = W_WORD;
      end
    end else begin
      // Hold the captured request on the RAM pins for the whole read latency.
      bus.mem_cke_o   = 1'b1;
      bus.mem_addr_o  = addr_q;
      bus.mem_width_o = width_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      flush_pend      <= 1'b0;
      addr_q          <= '0;
      width_q         <= '0;
      bus.i_rvalid_ro <= 1'b0;
      bus.i_rdata_ro  <= '0;
      bus.d_rvalid_ro <= 1'b0;
      bus.d_rdata_ro  <= '0;
    end else begin
      bus.i_rvalid_ro <= 1'b0;
      bus.d_rvalid_ro <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (d_acc && bus.d_write_i) begin
            bus.d_rvalid_ro <= 1'b1;
          end else if (d_acc) begin
            addr_q  <= bus.d_addr_i;
            width_q <= norm_width(bus.d_width_i);
            cnt     <= 2'(MEM_LAT - 1);
            state   <= ST_DBUSY;
          end else if (i_acc) begin
            addr_q     <= bus.i_addr_i;
            width_q    <= W_WORD;
            cnt        <= 2'(MEM_LAT - 1);
            flush_pend <= bus.flush_i;
            state      <= ST_IBUSY;
          end
        end
        ST_IBUSY: begin
          if (bus.flush_i) flush_pend <= 1'b1;
          if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else begin
            // A redirect seen at any point of the fetch kills its response.
            if (!(flush_pend || bus.flush_i)) begin
              bus.i_rvalid_ro <= 1'b1;
              bus.i_rdata_ro  <= bus.mem_rdata_i;
            end
            flush_pend <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        ST_DBUSY: begin
          if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else begin
            bus.d_rvalid_ro <= 1'b1;
            bus.d_rdata_ro  <= bus.mem_rdata_i;
            state           <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port unified memory between the instruction-fetch requester (insm side) and the data-access requester (execute/datam side). Grants one access at a time and sequences the fixed read latency of the memory. Returns read data or a write acknowledge to the granted requester. Sits between the pipeline stages and a unified RAM that replaces the separate insrom/dataram pair.

Parameters:
MEM_LAT, 1, memory read latency in cycles from the cke/addr cycle to valid mem_rdata_i (legal range 1..4)
AW, 32, address width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_valid_i  in  1  instruction read request
i_ready_o  out  1  instruction request accepted this cycle (combinational)
i_addr_i  in  AW  instruction address
i_rvalid_ro  out  1  instruction data valid, one-cycle pulse
i_rdata_ro  out  32  instruction data
d_valid_i  in  1  data request
d_ready_o  out  1  data request accepted this cycle (combinational)
d_addr_i  in  AW  data address
d_wdata_i  in  32  write data
d_write_i  in  1  1 = write, 0 = read
d_width_i  in  2  0 = byte, 1 = half, 2 = word
d_rvalid_ro  out  1  read data valid or write ack, one-cycle pulse
d_rdata_ro  out  32  data read result
flush_i  in  1  branch taken; cancels any outstanding instruction response
mem_cke_o  out  1  memory enable
mem_addr_o  out  AW  memory address
mem_wdata_o  out  32  memory write data
mem_write_o  out  1  memory write strobe
mem_width_o  out  2  memory access width
mem_rdata_i  in  32  memory read data

Behaviour:
- States: IDLE, IBUSY, DBUSY. Reset value: state IDLE; all *_ro outputs 0; cnt 0; flush_pend 0.
- Ready signals are asserted only in IDLE, and only to the granted requester. Grant with both requests valid: data port wins (default). An access is accepted when valid && ready.
- IDLE with an accepted access:
  - mem_cke_o = 1; mem_addr/wdata/write/width are driven combinationally from the granted port. An instruction access always drives write = 0 and width = 2.
  - Accepted write: mem_write_o = 1 that cycle; d_rvalid_ro pulses the next cycle; state stays IDLE. Back-to-back writes are accepted every cycle.
  - Accepted read: address and width are captured into registers; cnt <= MEM_LAT-1; state <= IBUSY or DBUSY.
- IBUSY/DBUSY:
  - mem_cke_o = 1 and mem_write_o = 0; mem address/width come from the captured registers.
  - If cnt != 0: cnt decrements.
  - If cnt == 0: the requester's rdata_ro <= mem_rdata_i and its rvalid_ro <= 1 (next cycle); state <= IDLE.
- Latency: a read accepted at cycle T returns rvalid at T+MEM_LAT+1. The next access can be accepted at T+MEM_LAT+1.
- Idle outputs: mem_cke_o = 0 and all mem_* outputs = 0 when IDLE with no accepted access.
- Flush:
  - flush_i in IBUSY sets flush_pend; the instruction response is then suppressed (i_rvalid_ro stays 0) and flush_pend clears on return to IDLE.
  - flush_i in the same cycle an instruction request is accepted also suppresses that response.
  - flush_i has no effect on data accesses or in DBUSY.
- rvalid pulses are not back-pressured; requesters must accept them.
- Reset mid-busy: the state returns to IDLE and any pending response is dropped (no rvalid).
- Invalid width 3: treated as word.
- No address decoding; MMIO snooping (0x000F0000 console) remains outside this block.

Optional Feature:
ARB_ROUND_ROBIN_EN:
- Defined: a last_grant register (reset value = data) is updated on every accepted access. When both ports are valid, the port not granted last wins, so the first conflict after reset goes to instruction.
- Undefined: fixed data priority; last_grant does not exist.

Decomposition:
- Shared package mem_pkg: state encoding (IDLE/IBUSY/DBUSY), width codes (W_BYTE = 0, W_HALF = 1, W_WORD = 2), and the console MMIO address constant for other blocks.
- One sub-module: arb_grant2, a combinational 2-way grant containing the fixed-priority and round-robin logic (the latter under the macro).

Test Plan:
- Reset held 3 cycles → all *_ro = 0 and mem_cke_o = 0. After release, i_valid_i = 1 → i_ready_o = 1 that cycle.
- Ifetch addr 0x100, MEM_LAT = 1, memory returns 0xDEADBEEF → mem_cke_o = 1 and mem_addr_o = 0x100 at T and T+1; i_rvalid_ro = 1 with i_rdata_ro = 0xDEADBEEF at T+2 only.
- i and d reads both valid at T (d addr 0x2000 → 0x11223344) → d granted at T, d_rvalid_ro at T+2; i granted at T+2 (without macro).
- Data writes to 0x000F0000 with 0x48, 0x69, width 0, on consecutive cycles → mem_write_o = 1 on both cycles; d_rvalid_ro pulses at T+1 and T+2; no stall.
- Ifetch at T with flush_i = 1 at T+1 → i_rvalid_ro stays 0; a new ifetch is accepted at T+2 and returns normally. rst asserted in DBUSY → no d_rvalid_ro, state IDLE.
- ARB_ROUND_ROBIN_EN defined, both reads continuously valid, MEM_LAT = 2 → grants alternate I, D, I, D; each accepted every 3 cycles.
